// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: shares one combinational ALU between two requesters with round-robin arbitration
module alu_rr_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPER_W = 82
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [2:0]        op0,
  input  logic [2:0]        op1,
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  b0,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b1,
  input  logic              cin0,
  input  logic              cin1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [WIDTH-1:0]  result,
  output logic              result_c,
  output logic              busy,
  output logic [OPER_W-1:0] alu_oper,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  input  logic [WIDTH-1:0]  alu_sum,
  input  logic              alu_cout
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [OPER_W-1:0] NAMES [8] = '{
    OPER_W'("and"), OPER_W'("subtract"), OPER_W'("subtract_a"), OPER_W'("or_ab"),
    OPER_W'("and_ab"), OPER_W'("not_ab"), OPER_W'("exor"), OPER_W'("exnor")
  };
  state_t state;
  logic last_owner;
  logic owner;
  logic win;
  logic [1:0] done_q;
  assign win = &req ? ~last_owner : req[1];
  assign grant = (state == IDLE && |req && !reset) ? {win, ~win} : 2'b00;
  // an op aborted by reset in its response cycle must not be reported
  assign done = reset ? 2'b00 : done_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_owner <= 1'b1;
      owner <= 1'b0;
      done_q <= 2'b00;
      result <= '0;
      result_c <= 1'b0;
      alu_oper <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
    end else begin
      done_q <= 2'b00;
      case (state)
        IDLE: if (|req) begin
          state <= EXEC;
          last_owner <= win;
          owner <= win;
          alu_oper <= NAMES[win ? op1 : op0];
          alu_a <= win ? a1 : a0;
          alu_b <= win ? b1 : b0;
          alu_cin <= win ? cin1 : cin0;
        end
        EXEC: begin
          state <= RESP;
          result <= alu_sum;
          result_c <= alu_cout;
          done_q <= {owner, ~owner};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb_alu_rr_sequencer: table-driven and scoreboarded checks of alu_rr_sequencer with an adder stub ALU
module tb_alu_rr_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [2:0] op0 = '0, op1 = '0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic cin0 = 1'b0, cin1 = 1'b0;
  logic [1:0] grant, done;
  logic [7:0] result, alu_a, alu_b, alu_sum;
  logic result_c, busy, alu_cin, alu_cout;
  logic [81:0] alu_oper;

  alu_rr_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
    .grant(grant), .done(done), .result(result), .result_c(result_c), .busy(busy),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  assign {alu_cout, alu_sum} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [81:0] act, input logic [81:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  logic [81:0] nm [8];
  typedef struct {logic [7:0] res; logic c; logic [81:0] oper;} exp_t;
  exp_t q[$];
  exp_t e;
  int mst = 0;
  bit mlast = 1'b1, mown = 1'b0, w;
  logic [1:0] eg;

  // cycle-level reference model of the arbiter and pipeline, plus result scoreboard
  always @(negedge clk) begin
    eg = 2'b00;
    w = 1'b0;
    if (!reset && mst == 0 && req != 2'b00) begin
      w = (req == 2'b11) ? !mlast : req[1];
      eg = w ? 2'b10 : 2'b01;
    end
    chk("grant", 82'(grant), 82'(eg));
    chk("busy", 82'(busy), 82'(mst != 0));
    chk("done", 82'(done), 82'((mst == 2 && !reset) ? (mown ? 2'b10 : 2'b01) : 2'b00));
    if (mst == 1 && q.size() > 0) chk("alu_oper", alu_oper, q[0].oper);
    if (mst == 2 && !reset && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_result", 82'(result), 82'(e.res));
      chk("sb_result_c", 82'(result_c), 82'(e.c));
    end
    if (reset) begin
      mst = 0;
      mlast = 1'b1;
      q.delete();
    end else if (mst == 0 && eg != 2'b00) begin
      {e.c, e.res} = 9'(w ? a1 : a0) + 9'(w ? b1 : b0) + 9'(w ? cin1 : cin0);
      e.oper = nm[w ? op1 : op0];
      q.push_back(e);
      mst = 1;
      mlast = w;
      mown = w;
    end else if (mst == 1) mst = 2;
    else if (mst == 2) mst = 0;
  end

  task automatic run_one(input int who, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input bit hold, input bit poke,
                         output logic [7:0] r, output logic c);
    int n;
    @(posedge clk); #2;
    if (who == 1) begin op1 = op; a1 = a; b1 = b; cin1 = cin; end
    else begin op0 = op; a0 = a; b0 = b; cin0 = cin; end
    req[who] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!grant[who] && n < 10);
    chk("grant_wait", 82'(grant[who]), 82'(1));
    @(posedge clk); #2;
    if (!hold) req[who] = 1'b0;
    if (poke) begin
      if (who == 1) a1 = 8'h00;
      else a0 = 8'h00;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!done[who] && n < 10);
    chk("done_latency", 82'(n), 82'(2));
    r = result;
    c = result_c;
    if (hold) begin @(posedge clk); #2; req[who] = 1'b0; end
  endtask

  typedef struct {int who; logic [2:0] op; logic [7:0] a; logic [7:0] b; logic cin; logic [7:0] res; logic c;} vec_t;
  vec_t tbl [8];
  logic [7:0] r;
  logic c;

  initial begin
    nm = '{82'("and"), 82'("subtract"), 82'("subtract_a"), 82'("or_ab"),
           82'("and_ab"), 82'("not_ab"), 82'("exor"), 82'("exnor")};
    tbl[0] = '{0, 3'd3, 8'h77, 8'hD0, 1'b1, 8'h48, 1'b1};
    tbl[1] = '{1, 3'd6, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[2] = '{0, 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1, 3'd7, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[4] = '{0, 3'd1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[5] = '{1, 3'd2, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    tbl[6] = '{0, 3'd4, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1, 3'd5, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_result", 82'({result_c, result}), 82'(0));
    chk("rst_alu", {alu_oper[64:0], alu_a, alu_b, alu_cin}, 82'(0));
    chk("rst_oper_hi", 82'(alu_oper[81:65]), 82'(0));
    for (int i = 0; i < 8; i++) begin
      run_one(tbl[i].who, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, i == 0, 1'b0, r, c);
      chk("tbl_result", 82'(r), 82'(tbl[i].res));
      chk("tbl_result_c", 82'(c), 82'(tbl[i].c));
    end
    for (int k = 0; k < 8; k++) begin
      run_one(0, 3'(k), 8'(k), 8'h10, 1'b0, 1'b0, 1'b0, r, c);
      chk("sweep_result", 82'(r), 82'(k + 16));
    end
    run_one(0, 3'd3, 8'h77, 8'hD0, 1'b1, 1'b1, 1'b1, r, c);
    chk("stable_result", 82'({c, r}), 82'(9'h148));
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    a0 = 8'h01; b0 = 8'h02; cin0 = 1'b0; op0 = 3'd6;
    a1 = 8'h10; b1 = 8'h20; cin1 = 1'b1; op1 = 3'd1;
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_grant", 82'(grant), 82'((k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00));
      chk("rr_done", 82'(done), 82'((k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00));
    end
    @(posedge clk); #2 req = 2'b00;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    op0 = 3'd3; a0 = 8'h77; b0 = 8'hD0; cin0 = 1'b1;
    req = 2'b01;
    @(negedge clk);
    chk("mid_grant", 82'(grant), 82'(2'b01));
    @(posedge clk); #2;
    reset = 1'b1;
    req = 2'b00;
    @(negedge clk);
    chk("mid_done", 82'(done), 82'(0));
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_outs", 82'({grant, done, busy, result_c, result}), 82'(0));
    chk("mid_alu", {alu_oper[64:0], alu_a, alu_b, alu_cin}, 82'(0));
    chk("mid_oper_hi", 82'(alu_oper[81:65]), 82'(0));
    @(posedge clk); #2 req = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", 82'(grant), 82'(2'b01));
    @(posedge clk); #2 req = 2'b00;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Shares one combinational 8-bit ALU (ports c_out, sum, oper, a, b, c_in) between two requesters, using round-robin arbitration.
- Each request is an operation code plus operands. The block latches it, drives the shared ALU for one cycle, registers the result and returns it with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the single ALU instance.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- OPER_W, 82, width of the ALU oper port (10 ASCII characters plus 2 bits), right-justified ASCII string.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  2  req[i] = requester i has an operation pending; held high until done[i]
- op0, op1  input  3  operation code per requester
- a0, b0, a1, b1  input  WIDTH  operands per requester
- cin0, cin1  input  1  carry-in per requester
- grant  output  2  one-hot, one-cycle pulse: request i accepted (operands latched)
- done  output  2  one-hot, one-cycle pulse: result for requester i valid
- result  output  WIDTH  registered ALU sum of the last completed op
- result_c  output  1  registered ALU c_out of the last completed op
- busy  output  1  high while an op is in flight (states EXEC, RESP)
- alu_oper  output  OPER_W  string driven to the ALU oper port
- alu_a, alu_b  output  WIDTH  to ALU a, b
- alu_cin  output  1  to ALU c_in
- alu_sum  input  WIDTH  from ALU sum
- alu_cout  input  1  from ALU c_out

Behaviour:
- Op code map:
  - 0 "and", 1 "subtract", 2 "subtract_a", 3 "or_ab"
  - 4 "and_ab", 5 "not_ab", 6 "exor", 7 "exnor"
  - Encoding is ASCII, right-justified, zero-padded on the left to OPER_W.
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- IDLE:
  - If any req bit is high: pick the winner, pulse grant[winner] and latch op/a/b/cin and the owner id into internal registers.
  - Next state EXEC.
  - If no req bit is high: stay in IDLE.
- EXEC:
  - alu_* outputs are driven from the latched registers.
  - At the clock edge, alu_sum/alu_cout are captured into result/result_c.
  - Next state RESP.
- RESP: done[owner] is high for exactly this cycle; next state IDLE.
- Timing:
  - Grant cycle T, done cycle T+2; the next grant is earliest T+3.
  - Throughput is one op per 3 cycles.
- Round-robin arbitration:
  - last_owner register, reset value 1, so requester 0 wins first.
  - If both requests are high, the winner is the requester that is not last_owner.
  - If only one is high, that one wins regardless of last_owner.
  - last_owner updates on grant.
- Outside EXEC:
  - alu_oper, alu_a, alu_b and alu_cin keep the latched values, so the ALU inputs do not toggle needlessly.
  - alu_oper is all zeros after reset, until the first grant.
- result/result_c:
  - Hold their value until the next capture.
  - They are shared by both requesters; a requester samples them only in its done cycle.
- Requester rules:
  - req[i] may drop after grant[i]; the op still completes and done[i] still pulses.
  - req[i] still high in the RESP cycle does not cause a re-grant before IDLE.
  - A requester must deassert req[i] in the cycle after done[i], or it is treated as a new request.
  - Op code/operand changes after grant are ignored.
- Reset values:
  - grant=0, done=0, busy=0, result=0, result_c=0.
  - alu_oper=0, alu_a=0, alu_b=0, alu_cin=0.
  - state=IDLE, last_owner=1.
- Reset asserted mid-op (EXEC or RESP): the op is aborted, no done pulse; all registers take reset values on that edge.
- Reset dominates any simultaneous req.

Test Plan:
- The bench uses a stub ALU: sum/c_out = a+b+c_in, for every oper.
- Single request: req=01, op0=3, a0=0x77, b0=0xD0, cin0=1.
  - Required: grant=01 at T, alu_oper="or_ab" during EXEC.
  - Required: done=01 at T+2 with result=0x48, result_c=1; busy high at T+1..T+2.
- Contention: req=11 from reset with both held.
  - Required: grants alternate 01,10,01,10 at T, T+3, T+6, T+9.
  - Required: each done arrives 2 cycles after its grant, with the matching owner.
- Early drop: req[1] pulsed for the grant cycle only, op1=6, a1=0x0F, b1=0x01, cin1=0.
  - Required: done=10 at T+2, result=0x10, result_c=0, then IDLE with no re-grant.
- Op-code sweep: requester 0 issues op codes 0..7 in sequence.
  - Required: alu_oper in EXEC equals "and", "subtract", "subtract_a", "or_ab", "and_ab", "not_ab", "exor", "exnor", right-justified ASCII.
- Reset mid-op: assert reset in the EXEC cycle.
  - Required: no done pulse; next cycle all outputs 0 and busy=0.
  - Required: with req=11 afterwards, requester 0 is granted first.
- Operand stability: change a0 from 0x77 to 0x00 in the EXEC cycle after grant.
  - Required: result still reflects 0x77 (0x48 with b0=0xD0, cin0=1).
